// File: rtl/ctrl_pipe.sv
// ctrl_pipe: parametrised control-bundle pipeline (stage 0 = execute).
// Each stage carries a valid bit and a WIDTH-bit decoded control bundle.
// Stalls propagate backwards through a hold chain. A flush clears its own
// stage. An exception kill masks the bundle leaving KILL_STAGE. A busy
// counter holds stage 0 while a multi-cycle mul/div operation completes.
// Optional feature macro: CTRL_PIPE_PERF_EN adds the stall and bubble
// performance counters. Without it, both perf outputs are tied to zero.
module ctrl_pipe #(
    parameter int              WIDTH      = 10,
    parameter int              STAGES     = 3,
    parameter int              KILL_STAGE = 0,
    parameter logic [WIDTH-1:0] KILL_MASK = 10'b0000100000,
    parameter int              MDU_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_ctrl,
    input  logic                      in_mdu,
    input  logic [STAGES-1:0]         stall_i,
    input  logic [STAGES-1:0]         flush_i,
    input  logic                      exc_kill,
    output logic                      ready_o,
    output logic [STAGES-1:0]         valid_o,
    output logic [STAGES*WIDTH-1:0]   ctrl_o,
    output logic                      mdu_busy_o,
    output logic [31:0]               perf_stall_o,
    output logic [31:0]               perf_bubble_o
);

    localparam int CNT_W = (MDU_CYCLES > 1) ? $clog2(MDU_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_CYCLES - 1);

    logic [STAGES-1:0] hold_s;
    logic [CNT_W-1:0]  mdu_cnt_r;
    logic              stage0_load_s;

    assign mdu_busy_o = (mdu_cnt_r != {CNT_W{1'b0}});
    assign ready_o    = ~hold_s[0];

    // Stage 0 accepts new input only when it is neither flushed nor held.
    assign stage0_load_s = ~flush_i[0] & ~hold_s[0];

    // Backward hold chain: a stage holds if it or any younger stage stalls.
    // Stage 0 also holds while the multi-cycle counter is busy.
    for (genvar h = 0; h < STAGES; h++) begin : g_hold
        if (h == 0) begin : g_h0
            assign hold_s[h] = (|stall_i) | mdu_busy_o;
        end else begin : g_hn
            assign hold_s[h] = |stall_i[STAGES-1:h];
        end
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic             valid_r;
        logic [WIDTH-1:0] ctrl_r;

        assign valid_o[i]                = valid_r;
        assign ctrl_o[i*WIDTH +: WIDTH]  = ctrl_r;

        if (i == 0) begin : g_s0
            // Execute stage: flush, else hold, else take the decode bundle.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_r <= 1'b0;
                    ctrl_r  <= {WIDTH{1'b0}};
                end else if (flush_i[i]) begin
                    valid_r <= 1'b0;
                    ctrl_r  <= {WIDTH{1'b0}};
                end else if (hold_s[i]) begin
                    valid_r <= valid_r;
                    ctrl_r  <= ctrl_r;
                end else begin
                    valid_r <= in_valid;
                    ctrl_r  <= in_valid ? in_ctrl : {WIDTH{1'b0}};
                end
            end
        end else begin : g_sn
            logic             src_bubble_s;
            logic [WIDTH-1:0] src_ctrl_s;

            // A held or invalid source delivers a bubble.
            assign src_bubble_s = hold_s[i-1] | ~valid_o[i-1];

            // Apply the exception kill mask on the transfer out of KILL_STAGE.
            always_comb begin
                src_ctrl_s = ctrl_o[(i-1)*WIDTH +: WIDTH];
                if ((i - 1 == KILL_STAGE) && exc_kill) begin
                    src_ctrl_s = ctrl_o[(i-1)*WIDTH +: WIDTH] & ~KILL_MASK;
                end else begin
                    src_ctrl_s = ctrl_o[(i-1)*WIDTH +: WIDTH];
                end
            end

            // Downstream stage: flush, else hold, else take from the older stage.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_r <= 1'b0;
                    ctrl_r  <= {WIDTH{1'b0}};
                end else if (flush_i[i]) begin
                    valid_r <= 1'b0;
                    ctrl_r  <= {WIDTH{1'b0}};
                end else if (hold_s[i]) begin
                    valid_r <= valid_r;
                    ctrl_r  <= ctrl_r;
                end else if (src_bubble_s) begin
                    valid_r <= 1'b0;
                    ctrl_r  <= {WIDTH{1'b0}};
                end else begin
                    valid_r <= 1'b1;
                    ctrl_r  <= src_ctrl_s;
                end
            end
        end
    end

    // Multi-cycle busy counter. It is armed by a valid mul/div entering
    // stage 0, counts down regardless of stalls, and is cleared by a stage-0 flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mdu_cnt_r <= {CNT_W{1'b0}};
        end else if (flush_i[0]) begin
            mdu_cnt_r <= {CNT_W{1'b0}};
        end else if (mdu_busy_o) begin
            mdu_cnt_r <= mdu_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (stage0_load_s && in_valid && in_mdu) begin
            mdu_cnt_r <= CNT_LOAD;
        end else begin
            mdu_cnt_r <= mdu_cnt_r;
        end
    end

`ifdef CTRL_PIPE_PERF_EN
    logic [31:0] perf_stall_r;
    logic [31:0] perf_bubble_r;
    logic        hold_bubble_s;

    // Stage 1 loads a bubble because stage 0 is held (not flushed, not held itself).
    assign hold_bubble_s = hold_s[0] & ~hold_s[1] & ~flush_i[1];
    assign perf_stall_o  = perf_stall_r;
    assign perf_bubble_o = perf_bubble_r;

    // Free-running, wrapping counters for stage-0 hold cycles and hold bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_r  <= 32'd0;
            perf_bubble_r <= 32'd0;
        end else begin
            perf_stall_r  <= perf_stall_r  + (hold_s[0]     ? 32'd1 : 32'd0);
            perf_bubble_r <= perf_bubble_r + (hold_bubble_s ? 32'd1 : 32'd0);
        end
    end
`else
    assign perf_stall_o  = 32'd0;
    assign perf_bubble_o = 32'd0;
`endif

endmodule
